// File: rtl/i2c_target_regs_if.sv
// Pin-level and local-host signal bundle for the I2C target register block.
// The slave modport is the target's view; the master modport is the bus/host side.
interface i2c_target_regs_if #(
   parameter int unsigned PTR_W = 7
);
   logic             scl_i;
   logic             sda_i;
   logic             sda_oe;
   logic             host_we;
   logic [PTR_W-1:0] host_addr;
   logic [7:0]       host_wdata;
   logic [7:0]       host_rdata;
   logic             bus_wr_pulse;
   logic [PTR_W-1:0] bus_wr_addr;
   logic             busy;

   modport slave (
      input  scl_i, sda_i, host_we, host_addr, host_wdata,
      output sda_oe, host_rdata, bus_wr_pulse, bus_wr_addr, busy
   );

   modport master (
      output scl_i, sda_i, host_we, host_addr, host_wdata,
      input  sda_oe, host_rdata, bus_wr_pulse, bus_wr_addr, busy
   );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 2**PTR_W byte register file, oversampled and glitch-filtered SCL/SDA,
// open-drain SDA, pointer auto-increment on reads and writes, and a local host port.
module i2c_target_regs #(
   parameter logic [6:0]  TARGET_ADDR = 7'h4D,
   parameter int unsigned PTR_W       = 7,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic               clk,
   input  logic               rstn,
   i2c_target_regs_if.slave   bus
);
   localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK,
      S_WR_DATA, S_W_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
   } state_e;

   // Bit 1 carries SCL, bit 0 carries SDA through sync, filter and edge stages.
   logic [1:0]       s1_q, s2_q, f_q, fp_q;
   logic [CNT_W-1:0] cnt_q [2];

   state_e           state_q;
   logic [7:0]       sh_q;
   logic [3:0]       bit_cnt_q;
   logic [PTR_W-1:0] ptr_q;
   logic             sda_oe_q, busy_q, bus_wr_pulse_q;
   logic [PTR_W-1:0] bus_wr_addr_q;
   logic [7:0]       regs_q [2**PTR_W];
   logic [7:0]       host_rdata_q;

   logic             scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
   logic             byte_done, host_hit, bus_we;
   logic [7:0]       rx_byte, rd_byte;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_q <= '1;
         s2_q <= '1;
         fp_q <= '1;
      end else begin
         s1_q <= {bus.scl_i, bus.sda_i};
         s2_q <= s1_q;
         fp_q <= f_q;
      end
   end

   // A level change is accepted only after FILTER_LEN consecutive differing samples.
   for (genvar g = 0; g < 2; g++) begin : g_filt
      always_ff @(posedge clk) begin
         if (!rstn) begin
            f_q[g]   <= 1'b1;
            cnt_q[g] <= '0;
         end else if (s2_q[g] == f_q[g]) begin
            cnt_q[g] <= '0;
         end else if (cnt_q[g] == CNT_MAX) begin
            f_q[g]   <= s2_q[g];
            cnt_q[g] <= '0;
         end else begin
            cnt_q[g] <= cnt_q[g] + 1'b1;
         end
      end
   end

   always_comb begin
      scl_f     = f_q[1];
      sda_f     = f_q[0];
      scl_rise  = scl_f & ~fp_q[1];
      scl_fall  = ~scl_f & fp_q[1];
      start_c   = scl_f & fp_q[1] & fp_q[0] & ~sda_f;
      stop_c    = scl_f & fp_q[1] & ~fp_q[0] & sda_f;
      rx_byte   = {sh_q[6:0], sda_f};
      byte_done = scl_rise && (bit_cnt_q == 4'd7);
      host_hit  = bus.host_we && (bus.host_addr == ptr_q);
      rd_byte   = host_hit ? bus.host_wdata : regs_q[ptr_q];
      bus_we    = (state_q == S_WR_DATA) && byte_done;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         regs_q       <= '{default: '0};
         host_rdata_q <= '0;
      end else begin
         if (bus_we && !host_hit) regs_q[ptr_q] <= rx_byte;
         if (bus.host_we) regs_q[bus.host_addr] <= bus.host_wdata;
         host_rdata_q <= regs_q[bus.host_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         sh_q           <= '0;
         bit_cnt_q      <= '0;
         ptr_q          <= '0;
         sda_oe_q       <= 1'b0;
         busy_q         <= 1'b0;
         bus_wr_pulse_q <= 1'b0;
         bus_wr_addr_q  <= '0;
      end else begin
         bus_wr_pulse_q <= 1'b0;
         if (start_c) begin
            state_q   <= S_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
         end else if (stop_c) begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE, S_IGNORE: sda_oe_q <= 1'b0;
               S_ADDR: if (scl_rise) begin
                  sh_q      <= rx_byte;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (byte_done) begin
                     bit_cnt_q <= '0;
                     busy_q    <= (rx_byte[7:1] == TARGET_ADDR);
                     state_q   <= (rx_byte[7:1] == TARGET_ADDR) ? S_A_ACK : S_IGNORE;
                  end
               end
               // sda_oe doubles as the ACK phase flag: first fall drives, second releases.
               S_A_ACK: if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_q <= 1'b1;
                  end else if (sh_q[0]) begin
                     sh_q     <= rd_byte;
                     sda_oe_q <= ~rd_byte[7];
                     state_q  <= S_RD_DATA;
                  end else begin
                     sda_oe_q <= 1'b0;
                     state_q  <= S_PTR;
                  end
               end
               S_PTR: if (scl_rise) begin
                  sh_q      <= rx_byte;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (byte_done) begin
                     bit_cnt_q <= '0;
                     ptr_q     <= rx_byte[PTR_W-1:0];
                     state_q   <= S_P_ACK;
                  end
               end
               S_P_ACK, S_W_ACK: if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_q <= 1'b1;
                  end else begin
                     sda_oe_q <= 1'b0;
                     state_q  <= S_WR_DATA;
                  end
               end
               S_WR_DATA: if (scl_rise) begin
                  sh_q      <= rx_byte;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (byte_done) begin
                     bit_cnt_q      <= '0;
                     bus_wr_pulse_q <= 1'b1;
                     bus_wr_addr_q  <= ptr_q;
                     ptr_q          <= ptr_q + 1'b1;
                     state_q        <= S_W_ACK;
                  end
               end
               S_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        bit_cnt_q <= '0;
                        sda_oe_q  <= 1'b0;
                        ptr_q     <= ptr_q + 1'b1;
                        state_q   <= S_RD_ACK;
                     end else begin
                        sh_q     <= {sh_q[6:0], 1'b0};
                        sda_oe_q <= ~sh_q[6];
                     end
                  end
               end
               // Any fall seen here follows an ACKed 9th clock; a NACK has already left.
               S_RD_ACK: begin
                  if (scl_rise && sda_f) begin
                     state_q <= S_IGNORE;
                  end else if (scl_fall) begin
                     sh_q     <= rd_byte;
                     sda_oe_q <= ~rd_byte[7];
                     state_q  <= S_RD_DATA;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.sda_oe       = sda_oe_q;
   assign bus.busy         = busy_q;
   assign bus.bus_wr_pulse = bus_wr_pulse_q;
   assign bus.bus_wr_addr  = bus_wr_addr_q;
   assign bus.host_rdata   = host_rdata_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master on a wired-AND SDA with pull-up,
// host-port preload/readback, and immediate-assertion checks against hand-computed values.
module tb_i2c_target_regs;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   hp    = 50;
   int   q     = 25;
   int   pulse_cnt = 0;
   logic [6:0] last_wr_addr = '0;
   logic oe_seen = 1'b0;

   always #50 clk = ~clk;

   i2c_target_regs_if #(.PTR_W(7)) bif ();

   assign bif.scl_i = m_scl;
   assign bif.sda_i = m_sda & ~bif.sda_oe;

   i2c_target_regs #(.TARGET_ADDR(7'h4D), .PTR_W(7), .FILTER_LEN(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif.slave)
   );

   always @(posedge clk) begin
      if (bif.bus_wr_pulse === 1'b1) begin
         pulse_cnt    = pulse_cnt + 1;
         last_wr_addr = bif.bus_wr_addr;
      end
      if (bif.sda_oe === 1'b1) oe_seen = 1'b1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wclk(q);
      m_scl = 1'b1; wclk(hp);
      m_sda = 1'b0; wclk(hp);
      m_scl = 1'b0; wclk(q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wclk(q);
      m_scl = 1'b1; wclk(hp);
      m_sda = 1'b1; wclk(hp);
   endtask

   // One SCL period; optional 1-clk inverted SDA pulse in the middle of the high phase.
   task automatic bit_xfer(input logic b, input bit glitch, output logic s);
      m_sda = b; wclk(q);
      m_scl = 1'b1; wclk(hp / 2);
      if (glitch) begin
         m_sda = ~b; wclk(1); m_sda = b;
      end else begin
         wclk(1);
      end
      wclk(hp - hp / 2 - 2);
      s = bif.sda_i;
      wclk(1);
      m_scl = 1'b0; wclk(q);
   endtask

   task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], gbit == i, s);
      bit_xfer(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, 1'b0, s);
         d[i] = s;
      end
      bit_xfer(mack, 1'b0, s);
   endtask

   task automatic host_write(input logic [6:0] a, input logic [7:0] d);
      bif.host_we = 1'b1; bif.host_addr = a; bif.host_wdata = d;
      wclk(1);
      bif.host_we = 1'b0;
   endtask

   task automatic host_read(input logic [6:0] a, output logic [7:0] d);
      bif.host_addr = a;
      wclk(2);
      d = bif.host_rdata;
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] d;
      int         p0, k;
      bif.host_we = 1'b0; bif.host_addr = '0; bif.host_wdata = '0;
      wclk(4);
      check("rst_sda_oe", bif.sda_oe, 0);
      check("rst_busy", bif.busy, 0);
      check("rst_wr_pulse", bif.bus_wr_pulse, 0);
      check("rst_rdata", bif.host_rdata, 0);
      rstn = 1'b1;
      wclk(10);

      // Case 1 at 100 kHz (clk 10 MHz): write 0x5C to regs[0x03].
      hp = 50; q = 25;
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c1_addr_ack", ack, 0);
      check("c1_busy", bif.busy, 1);
      write_byte(8'h83, -1, ack); check("c1_ptr_ack", ack, 0);
      write_byte(8'h5C, -1, ack); check("c1_data_ack", ack, 0);
      i2c_stop();
      check("c1_pulses", pulse_cnt - p0, 1);
      check("c1_wr_addr", last_wr_addr, 7'h03);
      check("c1_busy_after", bif.busy, 0);
      host_read(7'h03, d); check("c1_reg03", d, 8'h5C);
      // Current-address read exposes the pointer (expected 0x04).
      host_write(7'h04, 8'h66);
      wclk(10);
      i2c_start();
      write_byte(8'h9B, -1, ack); check("c1_rd_addr_ack", ack, 0);
      read_byte(1'b1, d); check("c1_ptr_is_04", d, 8'h66);
      i2c_stop();
      wclk(10);

      // Remaining cases at the filter-limited fast rate.
      hp = 10; q = 5;

      // Case 2: pointer write, repeated START, 2-byte read.
      host_write(7'h3B, 8'hA5);
      host_write(7'h3C, 8'h17);
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c2_addr_ack", ack, 0);
      write_byte(8'hBB, -1, ack); check("c2_ptr_ack", ack, 0);
      i2c_start();
      write_byte(8'h9B, -1, ack); check("c2_raddr_ack", ack, 0);
      read_byte(1'b0, d); check("c2_byte0", d, 8'hA5);
      read_byte(1'b1, d); check("c2_byte1", d, 8'h17);
      wclk(8);
      check("c2_released", bif.sda_oe, 0);
      i2c_stop();
      wclk(10);

      // Case 3: address mismatch is ignored.
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'h9C, -1, ack); check("c3_addr_nack", ack, 1);
      write_byte(8'h11, -1, ack); check("c3_byte_nack", ack, 1);
      check("c3_oe_never", oe_seen, 0);
      check("c3_busy", bif.busy, 0);
      i2c_stop();
      host_read(7'h11, d); check("c3_reg11", d, 8'h00);
      wclk(10);

      // Case 4: pointer wrap.
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c4_addr_ack", ack, 0);
      write_byte(8'h7F, -1, ack); check("c4_ptr_ack", ack, 0);
      write_byte(8'h01, -1, ack); check("c4_d0_ack", ack, 0);
      write_byte(8'h02, -1, ack); check("c4_d1_ack", ack, 0);
      i2c_stop();
      host_read(7'h7F, d); check("c4_reg7f", d, 8'h01);
      host_read(7'h00, d); check("c4_reg00", d, 8'h02);
      wclk(10);

      // Case 5a: 1-clk SDA glitch with SCL high inside a data byte is filtered.
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c5_addr_ack", ack, 0);
      write_byte(8'h20, -1, ack); check("c5_ptr_ack", ack, 0);
      write_byte(8'hFF, 3, ack);  check("c5_glitch_ack", ack, 0);
      i2c_stop();
      host_read(7'h20, d); check("c5_reg20", d, 8'hFF);
      wclk(10);
      // Case 5b: STOP after 4 data bits discards the partial byte.
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c5_ab_addr_ack", ack, 0);
      write_byte(8'h30, -1, ack); check("c5_ab_ptr_ack", ack, 0);
      bit_xfer(1'b1, 1'b0, s); bit_xfer(1'b0, 1'b0, s);
      bit_xfer(1'b1, 1'b0, s); bit_xfer(1'b0, 1'b0, s);
      i2c_stop();
      check("c5_ab_pulses", pulse_cnt - p0, 0);
      check("c5_ab_busy", bif.busy, 0);
      host_read(7'h30, d); check("c5_ab_reg30", d, 8'h00);
      wclk(10);

      // Case 6: reset while the target drives ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         d = 8'h9A;
         bit_xfer(d[i], 1'b0, s);
      end
      m_sda = 1'b1;
      k = 0;
      while (bif.sda_oe !== 1'b1 && k < 30) begin
         wclk(1);
         k++;
      end
      check("c6_ack_driven", bif.sda_oe, 1);
      rstn = 1'b0;
      wclk(1);
      check("c6_oe_released", bif.sda_oe, 0);
      wclk(2);
      rstn = 1'b1;
      m_scl = 1'b1; wclk(hp);
      m_scl = 1'b0; wclk(q);
      i2c_stop();
      wclk(10);
      p0 = pulse_cnt;
      i2c_start();
      write_byte(8'h9A, -1, ack); check("c6_addr_ack", ack, 0);
      write_byte(8'h83, -1, ack); check("c6_ptr_ack", ack, 0);
      write_byte(8'h5C, -1, ack); check("c6_data_ack", ack, 0);
      i2c_stop();
      check("c6_pulses", pulse_cnt - p0, 1);
      host_read(7'h03, d); check("c6_reg03", d, 8'h5C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
